// File: rtl/mem6502_responder_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem6502_responder_if : cpu6502 bus plus external I/O req/ack port         |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
interface mem6502_responder_if;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        rw;
  logic        clk2;
  logic        rdy;
  logic        io_req;
  logic        io_we;
  logic [7:0]  io_addr;
  logic [7:0]  io_wdata;
  logic        io_ack;
  logic [7:0]  io_rdata;

  modport slave (
    input  addr, wdata, rw, clk2, io_ack, io_rdata,
    output rdata, rdy, io_req, io_we, io_addr, io_wdata
  );

  modport master (
    output addr, wdata, rw, clk2, io_ack, io_rdata,
    input  rdata, rdy, io_req, io_we, io_addr, io_wdata
  );
endinterface
`default_nettype wire

// File: rtl/mem6502_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem6502_responder : cpu6502 bus target with RAM, vectors and bridged I/O  |
// | page; define MEM6502_WPROT_EN to write-protect RAM at/above WP_BASE.      |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module mem6502_responder #(
  parameter int          RAM_AW     = 8,
  parameter logic [7:0]  IO_PAGE    = 8'hD0,
  parameter logic [15:0] NMI_VEC    = 16'h0000,
  parameter logic [15:0] RST_VEC    = 16'h0000,
  parameter logic [15:0] IRQ_VEC    = 16'h0000,
  parameter logic [7:0]  FILL       = 8'hFF,
  parameter int          IO_TIMEOUT = 15,
  parameter logic [15:0] WP_BASE    = 16'h0080
) (
  input  logic               clk,
  input  logic               reset,
  mem6502_responder_if.slave bus,
  output logic               io_err,
  output logic               wp_err
);

  localparam int RAM_DEPTH = 1 << RAM_AW;
  localparam int CNT_W     = (IO_TIMEOUT < 2) ? 1 : $clog2(IO_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(IO_TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               clk2_q;
  logic [7:0]         rdata_q, rdata_d;
  logic               rdy_q, rdy_d;
  logic               io_req_q, io_req_d;
  logic               io_we_q, io_we_d;
  logic [7:0]         io_addr_q, io_addr_d;
  logic [7:0]         io_wdata_q, io_wdata_d;
  logic               io_err_q, io_err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;

  logic               phi2_rise, phi2_fall;
  logic               is_vec, is_io, is_ram;
  logic [7:0]         vec_byte, ram_byte, rd_path;
  logic               wr_ram, mem_we;
  logic [7:0]         mem_q [RAM_DEPTH];

  assign phi2_rise = bus.clk2 & ~clk2_q;
  assign phi2_fall = ~bus.clk2 & clk2_q;

  // Decode priority: vectors, then the I/O page, then RAM.
  always_comb begin
    is_vec = (bus.addr >= 16'hFFFA);
    is_io  = !is_vec && (bus.addr[15:8] == IO_PAGE);
    is_ram = !is_vec && !is_io && (bus.addr[15:RAM_AW] == '0);
  end

  always_comb begin
    vec_byte = FILL;
    case (bus.addr[2:0])
      3'b010:  vec_byte = NMI_VEC[7:0];
      3'b011:  vec_byte = NMI_VEC[15:8];
      3'b100:  vec_byte = RST_VEC[7:0];
      3'b101:  vec_byte = RST_VEC[15:8];
      3'b110:  vec_byte = IRQ_VEC[7:0];
      3'b111:  vec_byte = IRQ_VEC[15:8];
      default: vec_byte = FILL;
    endcase
  end

  assign ram_byte = mem_q[bus.addr[RAM_AW-1:0]];

  always_comb begin
    rd_path = FILL;
    if (is_vec) begin
      rd_path = vec_byte;
    end else if (is_ram) begin
      rd_path = ram_byte;
    end
  end

  assign wr_ram = phi2_fall && !bus.rw && is_ram;

`ifdef MEM6502_WPROT_EN
  logic wp_hit;
  logic wp_err_q, wp_err_d;

  assign wp_hit   = wr_ram && (bus.addr >= WP_BASE);
  assign wp_err_d = wp_err_q | wp_hit;
  assign mem_we   = wr_ram && !wp_hit;
  assign wp_err   = wp_err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp_err_q <= 1'b0;
    end else begin
      wp_err_q <= wp_err_d;
    end
  end
`else
  logic unused_wp_base;

  assign unused_wp_base = ^WP_BASE;
  assign mem_we         = wr_ram;
  assign wp_err         = 1'b0;
`endif

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[bus.addr[RAM_AW-1:0]] <= bus.wdata;
    end
  end

  assign cnt_inc = cnt_q + CNT_W'(1);

  // Timeout fires on the edge where the count reaches IO_TIMEOUT,
  // so rdy is low for exactly IO_TIMEOUT clks when no ack arrives.
  always_comb begin
    state_d    = state_q;
    rdata_d    = rd_path;
    rdy_d      = rdy_q;
    io_req_d   = io_req_q;
    io_we_d    = io_we_q;
    io_addr_d  = io_addr_q;
    io_wdata_d = io_wdata_q;
    io_err_d   = io_err_q;
    cnt_d      = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (phi2_rise && is_io) begin
          rdy_d      = 1'b0;
          io_req_d   = 1'b1;
          io_we_d    = ~bus.rw;
          io_addr_d  = bus.addr[7:0];
          io_wdata_d = bus.wdata;
          cnt_d      = '0;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        rdata_d = rdata_q;
        cnt_d   = cnt_inc;
        if (bus.io_ack) begin
          if (!io_we_q) begin
            rdata_d = bus.io_rdata;
          end
          io_req_d = 1'b0;
          rdy_d    = 1'b1;
          state_d  = S_DONE;
        end else if (cnt_inc == TIMEOUT_CNT) begin
          rdata_d  = FILL;
          io_req_d = 1'b0;
          rdy_d    = 1'b1;
          io_err_d = 1'b1;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        rdata_d = rdata_q;
        if (phi2_fall) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      clk2_q     <= 1'b0;
      rdata_q    <= FILL;
      rdy_q      <= 1'b1;
      io_req_q   <= 1'b0;
      io_we_q    <= 1'b0;
      io_addr_q  <= 8'h00;
      io_wdata_q <= 8'h00;
      io_err_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      clk2_q     <= bus.clk2;
      rdata_q    <= rdata_d;
      rdy_q      <= rdy_d;
      io_req_q   <= io_req_d;
      io_we_q    <= io_we_d;
      io_addr_q  <= io_addr_d;
      io_wdata_q <= io_wdata_d;
      io_err_q   <= io_err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.rdata    = rdata_q;
  assign bus.rdy      = rdy_q;
  assign bus.io_req   = io_req_q;
  assign bus.io_we    = io_we_q;
  assign bus.io_addr  = io_addr_q;
  assign bus.io_wdata = io_wdata_q;
  assign io_err       = io_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem6502_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mem6502_responder : directed bench acting as CPU bus master and I/O    |
// | device. Revision: 1.0                                                     |
// +--------------------------------------------------------------------------+
module tb_mem6502_responder;

  logic clk;
  logic reset;
  logic io_err;
  logic wp_err;

  int n_checks;
  int n_pass;
  int ack_delay;
  int ack_cnt;

  logic [7:0] rd, ioa, iowd, lo;
  logic       req, iowe;
  int         stall;

  mem6502_responder_if bus();

  mem6502_responder #(
    .RAM_AW    (8),
    .IO_PAGE   (8'hD0),
    .NMI_VEC   (16'hABCD),
    .RST_VEC   (16'h1234),
    .IRQ_VEC   (16'h5678),
    .FILL      (8'hFF),
    .IO_TIMEOUT(15),
    .WP_BASE   (16'h0080)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave),
    .io_err(io_err),
    .wp_err(wp_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // I/O device: one-clk ack pulse ack_delay clks after io_req rises (0 = never).
  initial begin
    bus.io_ack = 1'b0;
    ack_cnt    = 0;
    forever begin
      @(negedge clk);
      if (bus.io_ack) begin
        bus.io_ack = 1'b0;
      end else if (bus.io_req === 1'b1 && ack_delay > 0) begin
        ack_cnt++;
        if (ack_cnt == ack_delay) begin
          bus.io_ack = 1'b1;
          ack_cnt    = 0;
        end
      end else begin
        ack_cnt = 0;
      end
    end
  end

  task automatic bus_cycle(input logic [15:0] a, input logic r, input logic [7:0] wd);
    @(negedge clk);
    bus.addr  = a;
    bus.rw    = r;
    bus.wdata = wd;
    bus.clk2  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.clk2 = 1'b1;
    @(negedge clk);
    req   = bus.io_req;
    ioa   = bus.io_addr;
    iowe  = bus.io_we;
    iowd  = bus.io_wdata;
    stall = 0;
    while (bus.rdy !== 1'b1 && stall < 100) begin
      stall++;
      @(negedge clk);
    end
    if (stall >= 100) begin
      n_checks++;
      $display("FAIL bus_rdy_timeout: rdy=%b want 1", bus.rdy);
    end
    rd       = bus.rdata;
    bus.clk2 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++; if (bus.rdata !== 8'hFF) $display("FAIL rst_rdata: got %h want ff", bus.rdata); else n_pass++;
    n_checks++; if (bus.rdy !== 1'b1) $display("FAIL rst_rdy: got %b want 1", bus.rdy); else n_pass++;
    n_checks++; if (bus.io_req !== 1'b0) $display("FAIL rst_io_req: got %b want 0", bus.io_req); else n_pass++;
    n_checks++; if (bus.io_we !== 1'b0) $display("FAIL rst_io_we: got %b want 0", bus.io_we); else n_pass++;
    n_checks++; if (bus.io_addr !== 8'h00) $display("FAIL rst_io_addr: got %h want 00", bus.io_addr); else n_pass++;
    n_checks++; if (bus.io_wdata !== 8'h00) $display("FAIL rst_io_wdata: got %h want 00", bus.io_wdata); else n_pass++;
    n_checks++; if (io_err !== 1'b0) $display("FAIL rst_io_err: got %b want 0", io_err); else n_pass++;
    n_checks++; if (wp_err !== 1'b0) $display("FAIL rst_wp_err: got %b want 0", wp_err); else n_pass++;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_vectors();
    bus_cycle(16'hFFFC, 1'b1, 8'h00);
    lo = rd;
    n_checks++; if (rd !== 8'h34) $display("FAIL vec_rst_lo: got %h want 34", rd); else n_pass++;
    bus_cycle(16'hFFFD, 1'b1, 8'h00);
    n_checks++; if (rd !== 8'h12) $display("FAIL vec_rst_hi: got %h want 12", rd); else n_pass++;
    n_checks++; if ({rd, lo} !== 16'h1234) $display("FAIL vec_fetch_addr: got %h want 1234", {rd, lo}); else n_pass++;
    bus_cycle(16'hFFFA, 1'b1, 8'h00);
    n_checks++; if (rd !== 8'hCD) $display("FAIL vec_nmi_lo: got %h want cd", rd); else n_pass++;
    bus_cycle(16'hFFFB, 1'b1, 8'h00);
    n_checks++; if (rd !== 8'hAB) $display("FAIL vec_nmi_hi: got %h want ab", rd); else n_pass++;
    bus_cycle(16'hFFFE, 1'b1, 8'h00);
    n_checks++; if (rd !== 8'h78) $display("FAIL vec_irq_lo: got %h want 78", rd); else n_pass++;
    bus_cycle(16'hFFFF, 1'b1, 8'h00);
    n_checks++; if (rd !== 8'h56) $display("FAIL vec_irq_hi: got %h want 56", rd); else n_pass++;
  endtask

  task automatic test_ram();
    bus_cycle(16'h0010, 1'b0, 8'h5A);
    bus_cycle(16'h0010, 1'b1, 8'h00);
    n_checks++; if (rd !== 8'h5A) $display("FAIL ram_rd10: got %h want 5a", rd); else n_pass++;
    bus_cycle(16'h0011, 1'b0, rd);
    bus_cycle(16'h0011, 1'b1, 8'h00);
    n_checks++; if (rd !== 8'h5A) $display("FAIL ram_rd11: got %h want 5a", rd); else n_pass++;
    bus_cycle(16'h0000, 1'b0, 8'h3C);
    bus_cycle(16'h007E, 1'b0, 8'hC5);
    bus_cycle(16'h0000, 1'b1, 8'h00);
    n_checks++; if (rd !== 8'h3C) $display("FAIL ram_rd00: got %h want 3c", rd); else n_pass++;
    bus_cycle(16'h007E, 1'b1, 8'h00);
    n_checks++; if (rd !== 8'hC5) $display("FAIL ram_rd7e: got %h want c5", rd); else n_pass++;
  endtask

  task automatic test_unmapped();
    bus_cycle(16'h4000, 1'b1, 8'h00);
    n_checks++; if (rd !== 8'hFF) $display("FAIL unm_rd4000: got %h want ff", rd); else n_pass++;
    n_checks++; if (req !== 1'b0) $display("FAIL unm_no_req: got %b want 0", req); else n_pass++;
    n_checks++; if (stall !== 0) $display("FAIL unm_stall: got %0d want 0", stall); else n_pass++;
    bus_cycle(16'h0100, 1'b1, 8'h00);
    n_checks++; if (rd !== 8'hFF) $display("FAIL unm_rd0100: got %h want ff", rd); else n_pass++;
    bus_cycle(16'hFFFC, 1'b0, 8'h00);
    bus_cycle(16'hFFFC, 1'b1, 8'h00);
    n_checks++; if (rd !== 8'h34) $display("FAIL vec_write_ignored: got %h want 34", rd); else n_pass++;
    bus_cycle(16'h4000, 1'b0, 8'h12);
    bus_cycle(16'h4000, 1'b1, 8'h00);
    n_checks++; if (rd !== 8'hFF) $display("FAIL unm_write_ignored: got %h want ff", rd); else n_pass++;
  endtask

  task automatic test_io_read();
    ack_delay    = 3;
    bus.io_rdata = 8'hC3;
    bus_cycle(16'hD007, 1'b1, 8'h00);
    n_checks++; if (rd !== 8'hC3) $display("FAIL io_rd_data: got %h want c3", rd); else n_pass++;
    n_checks++; if (stall !== 3) $display("FAIL io_rd_stall: got %0d want 3", stall); else n_pass++;
    n_checks++; if (req !== 1'b1) $display("FAIL io_rd_req: got %b want 1", req); else n_pass++;
    n_checks++; if (ioa !== 8'h07) $display("FAIL io_rd_addr: got %h want 07", ioa); else n_pass++;
    n_checks++; if (iowe !== 1'b0) $display("FAIL io_rd_we: got %b want 0", iowe); else n_pass++;
    n_checks++; if (io_err !== 1'b0) $display("FAIL io_rd_err: got %b want 0", io_err); else n_pass++;
    n_checks++; if (bus.io_req !== 1'b0) $display("FAIL io_rd_req_drop: got %b want 0", bus.io_req); else n_pass++;
  endtask

  task automatic test_io_write();
    ack_delay = 2;
    bus_cycle(16'hD0A5, 1'b0, 8'h77);
    n_checks++; if (stall !== 2) $display("FAIL io_wr_stall: got %0d want 2", stall); else n_pass++;
    n_checks++; if (iowe !== 1'b1) $display("FAIL io_wr_we: got %b want 1", iowe); else n_pass++;
    n_checks++; if (ioa !== 8'hA5) $display("FAIL io_wr_addr: got %h want a5", ioa); else n_pass++;
    n_checks++; if (iowd !== 8'h77) $display("FAIL io_wr_wdata: got %h want 77", iowd); else n_pass++;
  endtask

  task automatic test_back_to_back();
    bus_cycle(16'h0020, 1'b0, 8'hA7);
    bus_cycle(16'h0020, 1'b1, 8'h00);
    n_checks++; if (rd !== 8'hA7) $display("FAIL b2b_ram: got %h want a7", rd); else n_pass++;
    ack_delay    = 1;
    bus.io_rdata = 8'h5E;
    bus_cycle(16'hD010, 1'b1, 8'h00);
    n_checks++; if (rd !== 8'h5E || stall !== 1) $display("FAIL b2b_io1: got %h/%0d want 5e/1", rd, stall); else n_pass++;
    bus.io_rdata = 8'hE5;
    bus_cycle(16'hD011, 1'b1, 8'h00);
    n_checks++; if (rd !== 8'hE5) $display("FAIL b2b_io2: got %h want e5", rd); else n_pass++;
    n_checks++; if (stall !== 1) $display("FAIL b2b_io2_stall: got %0d want 1", stall); else n_pass++;
    bus_cycle(16'h0020, 1'b1, 8'h00);
    n_checks++; if (rd !== 8'hA7) $display("FAIL b2b_ram_after_io: got %h want a7", rd); else n_pass++;
  endtask

  task automatic test_ack_timeout_tie();
    ack_delay    = 15;
    bus.io_rdata = 8'h3C;
    bus_cycle(16'hD033, 1'b1, 8'h00);
    n_checks++; if (rd !== 8'h3C) $display("FAIL tie_data: got %h want 3c", rd); else n_pass++;
    n_checks++; if (stall !== 15) $display("FAIL tie_stall: got %0d want 15", stall); else n_pass++;
    n_checks++; if (io_err !== 1'b0) $display("FAIL tie_io_err: got %b want 0", io_err); else n_pass++;
  endtask

  task automatic test_io_timeout();
    ack_delay = 0;
    bus_cycle(16'hD001, 1'b0, 8'h99);
    n_checks++; if (stall !== 15) $display("FAIL to_stall: got %0d want 15", stall); else n_pass++;
    n_checks++; if (rd !== 8'hFF) $display("FAIL to_rdata: got %h want ff", rd); else n_pass++;
    n_checks++; if (io_err !== 1'b1) $display("FAIL to_io_err: got %b want 1", io_err); else n_pass++;
    bus_cycle(16'h0010, 1'b1, 8'h00);
    n_checks++; if (rd !== 8'h5A || stall !== 0) $display("FAIL to_continue: got %h/%0d want 5a/0", rd, stall); else n_pass++;
    n_checks++; if (io_err !== 1'b1) $display("FAIL to_io_err_sticky: got %b want 1", io_err); else n_pass++;
  endtask

  task automatic test_reset_mid_access();
    ack_delay = 0;
    @(negedge clk);
    bus.addr = 16'hD002;
    bus.rw   = 1'b1;
    bus.clk2 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.clk2 = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.io_req !== 1'b1 || bus.rdy !== 1'b0) $display("FAIL mid_pending: got req=%b rdy=%b want 1/0", bus.io_req, bus.rdy); else n_pass++;
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    n_checks++; if (bus.io_req !== 1'b0) $display("FAIL mid_req_drop: got %b want 0", bus.io_req); else n_pass++;
    n_checks++; if (bus.rdy !== 1'b1) $display("FAIL mid_rdy: got %b want 1", bus.rdy); else n_pass++;
    n_checks++; if (io_err !== 1'b0) $display("FAIL mid_io_err_clr: got %b want 0", io_err); else n_pass++;
    bus.clk2 = 1'b0;
    bus.addr = 16'h0000;
    @(negedge clk);
    reset = 1'b1;
    bus_cycle(16'h0010, 1'b1, 8'h00);
    n_checks++; if (rd !== 8'h5A) $display("FAIL ram_kept_over_reset: got %h want 5a", rd); else n_pass++;
    ack_delay    = 1;
    bus.io_rdata = 8'h99;
    bus_cycle(16'hD0FF, 1'b1, 8'h00);
    n_checks++; if (rd !== 8'h99) $display("FAIL post_reset_io: got %h want 99", rd); else n_pass++;
    n_checks++; if (stall !== 1) $display("FAIL post_reset_io_stall: got %0d want 1", stall); else n_pass++;
  endtask

  task automatic test_wprot();
    ack_delay = 0;
    n_checks++; if (wp_err !== 1'b0) $display("FAIL wp_err_initial: got %b want 0", wp_err); else n_pass++;
    bus_cycle(16'h0080, 1'b0, 8'h01);
`ifdef MEM6502_WPROT_EN
    n_checks++; if (wp_err !== 1'b1) $display("FAIL wp_err_set: got %b want 1", wp_err); else n_pass++;
    bus_cycle(16'h0080, 1'b1, 8'h00);
    n_checks++; if (rd === 8'h01) $display("FAIL wp_blocked80: got %h want not 01", rd); else n_pass++;
`else
    n_checks++; if (wp_err !== 1'b0) $display("FAIL wp_err_tied: got %b want 0", wp_err); else n_pass++;
    bus_cycle(16'h0080, 1'b1, 8'h00);
    n_checks++; if (rd !== 8'h01) $display("FAIL wp_write80: got %h want 01", rd); else n_pass++;
`endif
    bus_cycle(16'h007F, 1'b0, 8'h01);
    bus_cycle(16'h007F, 1'b1, 8'h00);
    n_checks++; if (rd !== 8'h01) $display("FAIL wp_write7f: got %h want 01", rd); else n_pass++;
    bus_cycle(16'h00FF, 1'b0, 8'hEE);
    bus_cycle(16'h00FF, 1'b1, 8'h00);
`ifdef MEM6502_WPROT_EN
    n_checks++; if (rd === 8'hEE) $display("FAIL wp_blockedff: got %h want not ee", rd); else n_pass++;
    n_checks++; if (wp_err !== 1'b1) $display("FAIL wp_err_sticky: got %b want 1", wp_err); else n_pass++;
`else
    n_checks++; if (rd !== 8'hEE) $display("FAIL ram_topff: got %h want ee", rd); else n_pass++;
    n_checks++; if (wp_err !== 1'b0) $display("FAIL wp_err_stays0: got %b want 0", wp_err); else n_pass++;
`endif
  endtask

  initial begin
    n_checks     = 0;
    n_pass       = 0;
    ack_delay    = 0;
    bus.addr     = 16'h0000;
    bus.wdata    = 8'h00;
    bus.rw       = 1'b1;
    bus.clk2     = 1'b0;
    bus.io_rdata = 8'h00;
    reset        = 1'b0;
    test_reset();
    test_vectors();
    test_ram();
    test_unmapped();
    test_io_read();
    test_io_write();
    test_back_to_back();
    test_ack_timeout_tie();
    test_io_timeout();
    test_reset_mid_access();
    test_wprot();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
